toggle_monitor: RTL

TOGGLE_MONITOR -- requirements
Module: toggle_monitor

---
 rtl/toggle_monitor_pkg.sv | 20 ++
 rtl/toggle_monitor_popcount.sv | 18 +
 rtl/toggle_monitor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/toggle_monitor_pkg.sv
// Shared types and sizing helpers for the adder toggle monitor and its relatives.
package toggle_pkg;

    localparam int DATA_W_DEF = 33;
    localparam int CNT_W_DEF  = 32;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        COUNT,
        DRAIN,
        DONE
    } state_t;

    // Bits needed to hold a population count of a w-bit word (0..w inclusive).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/toggle_monitor_popcount.sv
// Purely combinational population count, sized for any word width.
module popcount #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0]             data,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CW'(data[i]);
        end
    end

endmodule

// File: rtl/toggle_monitor.sv
// Measures switching activity of an adder output word over a window of transitions:
// total bit flips, number of transitions and the worst single-transition flip count.
module toggle_monitor
    import toggle_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [15:0]                    window_len,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           busy,
    output logic                           done,
    output logic [CNT_W-1:0]               toggle_total,
    output logic [15:0]                    sample_count,
    output logic [cnt_width(DATA_W)-1:0]   max_toggles
);

    localparam int PC_W = cnt_width(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] prev;
    logic [PC_W-1:0]   pc_now;
    logic [PC_W-1:0]   pc_reg;
    logic              pc_valid;
    logic [15:0]       win_len;
    logic [15:0]       trans_cnt;
    logic              accept;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  total_next;

    assign accept = in_valid & in_ready;

    // One spare carry bit detects overflow so the total clamps instead of wrapping.
    assign sum        = {1'b0, toggle_total} + (CNT_W + 1)'(pc_reg);
    assign total_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

    popcount #(.WIDTH(DATA_W)) u_popcount (
        .data  (in_data ^ prev),
        .count (pc_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev         <= '0;
            pc_reg       <= '0;
            pc_valid     <= 1'b0;
            win_len      <= '0;
            trans_cnt    <= '0;
            toggle_total <= '0;
            sample_count <= '0;
            max_toggles  <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done     <= 1'b0;
            pc_valid <= 1'b0;

            // Second pipeline stage: fold the previously registered flip count in.
            if (pc_valid) begin
                toggle_total <= total_next;
                sample_count <= sample_count + 16'd1;
                if (pc_reg > max_toggles) begin
                    max_toggles <= pc_reg;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        toggle_total <= '0;
                        sample_count <= '0;
                        max_toggles  <= '0;
                        trans_cnt    <= '0;
                        if (window_len != 16'd0) begin
                            win_len  <= window_len;
                            state    <= PRIME;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                PRIME: begin
                    if (accept) begin
                        prev  <= in_data;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        prev      <= in_data;
                        pc_reg    <= pc_now;
                        pc_valid  <= 1'b1;
                        trans_cnt <= trans_cnt + 16'd1;
                        if (trans_cnt + 16'd1 == win_len) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state <= DONE;
                    busy  <= 1'b0;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
